instr_encoder_loader: RTL and testbench

Encoder and writer counterpart to the main control decoder. It accepts instruction fields over a valid/ready handshake and assembles 32-bit MIPS words for the supported opcodes (R-format, j, lw, sw, beq, addi). It writes each word into instruction memory at sequential word addresses, holding every write until the memory acknowledges it. It is used by the test/boot path to load programs that the decoder later consumes.

---
 rtl/instr_encoder_loader_if.sv | 32 +++
 rtl/instr_encoder_loader.sv | 121 ++++++++++++
 tb/tb_instr_encoder_loader.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Field-input handshake and instruction-memory write port of the loader.
// The field producer uses 'master'; the loader uses 'slave'.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;

  modport master (
    output in_valid, in_class, in_rs, in_rt, in_rd, in_shamt, in_funct,
           in_imm, in_target, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_class, in_rs, in_rt, in_rd, in_shamt, in_funct,
           in_imm, in_target, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Assembles MIPS instruction words from fields and writes them to instruction
// memory at sequential word addresses, one outstanding write at a time.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  clr,
  instr_encoder_loader_if.slave bus,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              err_reg, err_next;
  logic [31:0]       word_reg, word_next;

  logic [31:0]       enc_word;
  logic              class_ok;

  // Field encoder; unused fields of each class are simply not routed.
  always_comb begin
    enc_word = 32'd0;
    class_ok = 1'b1;
    case (bus.in_class)
      3'd0: enc_word = {OP_R, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
      3'd1: enc_word = {OP_J, bus.in_target};
      3'd2: enc_word = {OP_LW, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd3: enc_word = {OP_SW, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd4: enc_word = {OP_BEQ, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd5: enc_word = {OP_ADDI, bus.in_rs, bus.in_rt, bus.in_imm};
      default: class_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    err_next    = err_reg;
    word_next   = word_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          if (class_ok) begin
            word_next  = enc_word;
            state_next = WRITE;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      WRITE: begin
        if (bus.mem_ack) begin
          count_next = count_reg + (ADDR_W + 1)'(1);
          // The pointer parks on the last address so it never wraps.
          if (wr_ptr_reg == LAST_ADDR) begin
            state_next = FULL;
          end else begin
            wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
            state_next  = IDLE;
          end
        end
      end
      FULL: begin
        state_next = FULL;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN || clr) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
      word_reg   <= 32'd0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      err_reg    <= err_next;
      word_reg   <= word_next;
    end
  end

  // Address and data come straight from registers, so they hold during a wait.
  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.mem_we    = (state_reg == WRITE);
  assign bus.mem_addr  = wr_ptr_reg;
  assign bus.mem_wdata = word_reg;

  assign count = count_reg;
  assign full  = (state_reg == FULL);
  assign err   = err_reg;
  assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader (DEPTH=4): stimulus pushes expected
// writes, a negedge monitor pops and compares each acknowledged write.
module tb_instr_encoder_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic resetN;
  logic clr;
  logic [ADDR_W:0] count;
  logic full, err, busy;

  instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .resetN(resetN),
    .clr   (clr),
    .bus   (bus),
    .count (count),
    .full  (full),
    .err   (err),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W-1:0]  exp_ptr;

  int ack_delay = 0;
  bit ack_always = 1'b0;
  int wait_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Memory acknowledge model: ack after ack_delay waiting cycles, or always high.
  always @(posedge clk) begin
    #2;
    if (ack_always) begin
      bus.mem_ack = 1'b1;
    end else if (bus.mem_we) begin
      bus.mem_ack = (wait_cnt >= ack_delay);
      wait_cnt++;
    end else begin
      bus.mem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // Monitor: hold-stability while waiting, in_ready low during writes, scoreboard pop on ack.
  logic              prev_wait = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [31:0]       prev_data;
  always @(negedge clk) begin
    if (resetN && !clr && bus.mem_we) begin
      if (prev_wait) begin
        check("hold_addr", 64'(bus.mem_addr), 64'(prev_addr));
        check("hold_wdata", 64'(bus.mem_wdata), 64'(prev_data));
      end
      check("ready_low_in_write", 64'(bus.in_ready), 64'd0);
      if (bus.mem_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(bus.mem_addr), 64'hFFFF_FFFF_FFFF);
        end else begin
          logic [ADDR_W+31:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(bus.mem_addr), 64'(e[ADDR_W+31:32]));
          check("wr_data", 64'(bus.mem_wdata), 64'(e[31:0]));
        end
      end
      prev_wait = !bus.mem_ack;
      prev_addr = bus.mem_addr;
      prev_data = bus.mem_wdata;
    end else begin
      prev_wait = 1'b0;
    end
  end

  task automatic send(input logic [2:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                      input logic [15:0] imm, input logic [25:0] target, input logic [31:0] exp_word);
    int n;
    bus.in_valid  = 1'b1;
    bus.in_class  = cls;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_rd     = rd;
    bus.in_shamt  = shamt;
    bus.in_funct  = funct;
    bus.in_imm    = imm;
    bus.in_target = target;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'(bus.in_ready), 64'd1);
    end else if (cls < 3'd6) begin
      exp_q.push_back({exp_ptr, exp_word});
      exp_ptr = exp_ptr + 1'b1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.mem_we) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    exp_q.delete();
    exp_ptr = '0;
  endtask

  initial begin
    resetN = 1'b0;
    clr = 1'b0;
    exp_ptr = '0;
    bus.in_valid = 1'b0;
    bus.in_class = 3'd0;
    bus.in_rs = 5'd0;
    bus.in_rt = 5'd0;
    bus.in_rd = 5'd0;
    bus.in_shamt = 5'd0;
    bus.in_funct = 6'd0;
    bus.in_imm = 16'd0;
    bus.in_target = 26'd0;
    bus.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    @(negedge clk);
    check("rst_count", 64'(count), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // add $3,$1,$2 with ack tied high: exactly one cycle of mem_we
    ack_always = 1'b1;
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 32'h0022_1820);
    @(negedge clk);
    check("t1_we_cycle1", 64'(bus.mem_we), 64'd1);
    @(negedge clk);
    check("t1_we_cycle2", 64'(bus.mem_we), 64'd0);
    check("t1_ready_again", 64'(bus.in_ready), 64'd1);
    check("t1_count", 64'(count), 64'd1);
    check("t1_queue", 64'(exp_q.size()), 64'd0);
    ack_always = 1'b0;
    @(posedge clk);
    #1;
    do_clr();
    @(negedge clk);
    check("clr_count", 64'(count), 64'd0);
    @(posedge clk);
    #1;

    // lw / sw with a 3-cycle acknowledge delay
    ack_delay = 3;
    send(3'd2, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 32'h8D28_0004);
    send(3'd3, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0000, 26'd0, 32'hAFA8_0000);
    wait_drain();
    check("t2_count", 64'(count), 64'd2);
    do_clr();

    // beq / j / addi back to back
    ack_delay = 0;
    send(3'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 32'h1022_FFFF);
    send(3'd1, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h010_0000, 32'h0810_0000);
    send(3'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 32'h2008_0005);
    wait_drain();
    check("t3_count", 64'(count), 64'd3);
    do_clr();

    // invalid class sets err and writes nothing; next valid entry lands at 0
    send(3'd6, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 32'd0);
    @(negedge clk);
    check("t4_err_set", 64'(err), 64'd1);
    check("t4_no_write", 64'(bus.mem_we), 64'd0);
    check("t4_count0", 64'(count), 64'd0);
    @(posedge clk);
    #1;
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 32'h0022_1820);
    wait_drain();
    check("t4_err_sticky", 64'(err), 64'd1);
    check("t4_count1", 64'(count), 64'd1);
    do_clr();
    @(negedge clk);
    check("t4_err_cleared", 64'(err), 64'd0);
    @(posedge clk);
    #1;

    // fill all DEPTH words, fifth entry must be refused
    for (int i = 0; i < DEPTH; i++) begin
      send(3'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'(i), 26'd0, 32'h2008_0000 | 32'(i));
    end
    wait_drain();
    bus.in_valid = 1'b1;
    bus.in_class = 3'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_ready_low", 64'(bus.in_ready), 64'd0);
      check("t5_no_we", 64'(bus.mem_we), 64'd0);
    end
    check("t5_full", 64'(full), 64'd1);
    check("t5_count", 64'(count), 64'(DEPTH));
    check("t5_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;

    // reset while FULL
    resetN = 1'b0;
    @(posedge clk);
    #1;
    resetN = 1'b1;
    exp_q.delete();
    exp_ptr = '0;
    @(negedge clk);
    check("t6_full_cleared", 64'(full), 64'd0);
    check("t6_count0", 64'(count), 64'd0);
    check("t6_we0", 64'(bus.mem_we), 64'd0);
    @(posedge clk);
    #1;

    // clr during a stalled write aborts it
    ack_delay = 1000;
    send(3'd0, 5'd4, 5'd5, 5'd6, 5'd2, 6'h00, 16'd0, 26'd0, 32'h0085_3080);
    @(negedge clk);
    check("t6_we_pending", 64'(bus.mem_we), 64'd1);
    @(posedge clk);
    #1;
    do_clr();
    @(negedge clk);
    check("t6_we_aborted", 64'(bus.mem_we), 64'd0);
    check("t6_count_clr", 64'(count), 64'd0);
    check("t6_err_clr", 64'(err), 64'd0);
    check("t6_full_clr", 64'(full), 64'd0);
    @(posedge clk);
    #1;
    ack_delay = 0;
    send(3'd2, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 32'h8D28_0004);
    wait_drain();
    check("t6_count1", 64'(count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
